// File: rtl/ibex_bloom_unit.sv
// Bloom-filter coprocessor for the EX stage: INSERT/CHECK probe a
// 32x32-bit array, CLEAR sweeps it, COUNT returns the insert count.
// Ports: clk_i, rst_i (sync, active-high); custom_en_i/custom_op_i,
// custom_rs1_i/custom_rs2_i in; custom_ready_o, custom_valid_o,
// custom_result_o, custom_err_o out.
module ibex_bloom_unit #(
  parameter int unsigned NumHashes = 3,
  parameter int unsigned NumWords  = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        custom_en_i,
  input  logic [4:0]  custom_op_i,
  input  logic [31:0] custom_rs1_i,
  input  logic [31:0] custom_rs2_i,
  output logic        custom_ready_o,
  output logic        custom_valid_o,
  output logic [31:0] custom_result_o,
  output logic        custom_err_o
);

  localparam int unsigned AW =
    (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned SW = (AW > 2) ? AW : 2;

  localparam logic [4:0] OpInsert = 5'd1;
  localparam logic [4:0] OpCheck  = 5'd2;
  localparam logic [4:0] OpClear  = 5'd3;
  localparam logic [4:0] OpCount  = 5'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROBE,
    S_SWEEP,
    S_RESP
  } state_e;

  state_e r_state;
  state_e w_next;

  logic [4:0]    r_op;
  logic [31:0]   r_key;
  logic [SW-1:0] r_step;
  logic          r_hit;
  logic [31:0]   r_count;
  logic [31:0]   r_mem [NumWords];

  logic [31:0] w_seed;
  logic [31:0] w_x;
  logic [9:0]  w_idx;
  logic [4:0]  w_word;
  logic [4:0]  w_bit;
  logic        w_probe_last;
  logic        w_sweep_last;
  logic        w_r_legal;

  // r_step doubles as the probe number (PROBE) and word address (SWEEP)
  always_comb begin
    w_seed = 32'h0;
    unique case (r_step[1:0])
      2'd0: w_seed = 32'h9E3779B9;
      2'd1: w_seed = 32'h85EBCA6B;
      2'd2: w_seed = 32'hC2B2AE35;
      2'd3: w_seed = 32'h27D4EB2F;
    endcase
  end

  assign w_x   = r_key ^ w_seed;
  assign w_idx = w_x[9:0] ^ w_x[19:10] ^ w_x[29:20]
               ^ {8'b0, w_x[31:30]};
  assign w_word = w_idx[9:5];
  assign w_bit  = w_idx[4:0];

  assign w_probe_last = (r_step == SW'(NumHashes - 1));
  assign w_sweep_last = (r_step == SW'(NumWords - 1));
  assign w_r_legal    = (r_op >= OpInsert) && (r_op <= OpCount);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (custom_en_i) begin
          unique case (1'b1)
            (custom_op_i == OpInsert),
            (custom_op_i == OpCheck):  w_next = S_PROBE;
            (custom_op_i == OpClear):  w_next = S_SWEEP;
            default:                   w_next = S_RESP;
          endcase
        end
      end
      S_PROBE: if (w_probe_last) w_next = S_RESP;
      S_SWEEP: if (w_sweep_last) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op    <= '0;
      r_key   <= '0;
      r_step  <= '0;
      r_hit   <= 1'b0;
      r_count <= '0;
      for (int i = 0; i < NumWords; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (custom_en_i) begin
            r_op   <= custom_op_i;
            r_key  <= custom_rs1_i ^ custom_rs2_i;
            r_step <= '0;
            r_hit  <= 1'b1;
            if (custom_op_i == OpInsert && r_count != '1)
              r_count <= r_count + 32'd1;
          end
        end
        S_PROBE: begin
          r_step <= r_step + 1'b1;
          if (r_op == OpInsert)
            r_mem[w_word][w_bit] <= 1'b1;
          else
            r_hit <= r_hit & r_mem[w_word][w_bit];
        end
        S_SWEEP: begin
          r_step <= r_step + 1'b1;
          r_mem[r_step[AW-1:0]] <= '0;
          r_count <= '0;
        end
        default: ;
      endcase
    end
  end

  assign custom_ready_o = (r_state == S_IDLE);
  assign custom_valid_o = (r_state == S_RESP);
  assign custom_err_o   = custom_valid_o & ~w_r_legal;

  always_comb begin
    custom_result_o = '0;
    if (custom_valid_o) begin
      unique case (1'b1)
        (r_op == OpCheck): custom_result_o = {31'b0, r_hit};
        (r_op == OpCount): custom_result_o = r_count;
        default:           custom_result_o = '0;
      endcase
    end
  end

endmodule
